// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA writeback stage.
// Holds the buffered entry layout and the operation-class decode.
package ula_pkg;

  localparam int unsigned DATA_W = 3;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 5'b11111;

  typedef enum logic [1:0] {
    CLS_ARITH,
    CLS_LOGIC,
    CLS_NOP
  } op_class_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] dest;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;  // {O,C,S,Z}
  } wb_entry_t;

  // ARITH when the two top opcode bits are clear; the all-ones opcode is NOP.
  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    op_class_e cls;
    cls = CLS_LOGIC;
    if (op == OP_NOP) begin
      cls = CLS_NOP;
    end else if (op[OP_W-1 -: 2] == 2'b00) begin
      cls = CLS_ARITH;
    end
    return cls;
  endfunction

endpackage

// File: rtl/ula_wb_fifo.sv
// Two-entry synchronous FIFO with valid/ready on both sides.
// Ready depends only on the occupancy register, so there is no ready-to-ready path.
module ula_wb_fifo
  import ula_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  logic [W-1:0] mem [DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count < 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign busy      = out_valid;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Occupancy and pointers; a full FIFO ignores a same-cycle push even when popping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is written only on an accepted push, so idle-cycle garbage never lands.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/ula_wb.sv
// ULA writeback/retire stage: buffers results, retires in order into the
// register bank and architectural flags, and exposes the commit record.
module ula_wb
  import ula_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [OP_W-1:0]   IN_OP,
  input  logic [ADDR_W-1:0] IN_DEST,
  input  logic              IN_WE,
  input  logic [DATA_W-1:0] RESU,
  input  logic              O,
  input  logic              C,
  input  logic              S,
  input  logic              Z,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] OUT_DEST,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [FLAG_W-1:0] OUT_FLAGS,
  output logic [FLAG_W-1:0] FLAGS,
  input  logic [ADDR_W-1:0] RD_ADDR_A,
  input  logic [ADDR_W-1:0] RD_ADDR_B,
  output logic [DATA_W-1:0] RD_DATA_A,
  output logic [DATA_W-1:0] RD_DATA_B,
  output logic              BUSY
);

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  wb_entry_t          in_entry;
  wb_entry_t          head;
  logic [ENTRY_W-1:0] head_bits;
  logic               retire;
  op_class_e          head_cls;
  logic [DATA_W-1:0]  regs [NREGS];
  logic [FLAG_W-1:0]  flags_q;

  always_comb begin
    in_entry       = '0;
    in_entry.op    = IN_OP;
    in_entry.dest  = IN_DEST;
    in_entry.we    = IN_WE;
    in_entry.data  = RESU;
    in_entry.flags = {O, C, S, Z};
  end

  ula_wb_fifo #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (IN_VALID),
    .in_ready  (IN_READY),
    .in_data   (in_entry),
    .out_valid (OUT_VALID),
    .out_ready (OUT_READY),
    .out_data  (head_bits),
    .busy      (BUSY)
  );

  assign head      = wb_entry_t'(head_bits);
  assign OUT_DEST  = head.dest;
  assign OUT_DATA  = head.data;
  assign OUT_FLAGS = head.flags;
  assign retire    = OUT_VALID && OUT_READY;
  assign head_cls  = op_class(head.op);

  // Retire effects: bank write and class-dependent flag update on the pop edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
      flags_q <= '0;
    end else if (retire) begin
      if (head.we && (head_cls != CLS_NOP)) begin
        regs[head.dest] <= head.data;
      end
      case (head_cls)
        CLS_ARITH: flags_q <= head.flags;
        CLS_LOGIC: flags_q <= {flags_q[3:2], head.flags[1:0]};
        default:   flags_q <= flags_q;
      endcase
    end
  end

  assign FLAGS     = flags_q;
  assign RD_DATA_A = regs[RD_ADDR_A];
  assign RD_DATA_B = regs[RD_ADDR_B];

endmodule

// File: tb/tb_ula_wb.sv
// Scoreboard bench for ula_wb: driver queues expected commits, a negedge
// monitor checks the head, handshake state, flags and read ports against a model.
module tb_ula_wb;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [4:0] IN_OP;
  logic [2:0] IN_DEST;
  logic       IN_WE;
  logic [2:0] RESU;
  logic       O, C, S, Z;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [2:0] OUT_DEST;
  logic [2:0] OUT_DATA;
  logic [3:0] OUT_FLAGS;
  logic [3:0] FLAGS;
  logic [2:0] RD_ADDR_A, RD_ADDR_B;
  logic [2:0] RD_DATA_A, RD_DATA_B;
  logic       BUSY;

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] dest;
    logic       we;
    logic [2:0] data;
    logic [3:0] fl;
  } txn_t;

  txn_t       sb[$];
  txn_t       head_t;
  logic [2:0] mdl_regs [8];
  logic [3:0] mdl_flags;
  int         vectors = 0;
  int         miscompares = 0;
  bit         rd_rand = 1'b1;
  bit         stim_done;

  always #5 CLK = ~CLK;

  ula_wb dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP), .IN_DEST(IN_DEST),
    .IN_WE(IN_WE), .RESU(RESU), .O(O), .C(C), .S(S), .Z(Z),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DEST(OUT_DEST),
    .OUT_DATA(OUT_DATA), .OUT_FLAGS(OUT_FLAGS), .FLAGS(FLAGS),
    .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B), .BUSY(BUSY)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural effect of retiring one entry, from the class rules.
  task automatic model_retire(input txn_t t);
    if (t.op != 5'd31) begin
      if (t.we) mdl_regs[t.dest] = t.data;
      if (t.op < 5'd8) mdl_flags = t.fl;
      else             mdl_flags = {mdl_flags[3:2], t.fl[1:0]};
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
      for (int i = 0; i < 8; i++) mdl_regs[i] = 3'd0;
      mdl_flags = 4'd0;
    end else begin
      chk("busy",      int'(BUSY),      int'(sb.size() != 0));
      chk("out_valid", int'(OUT_VALID), int'(sb.size() != 0));
      chk("in_ready",  int'(IN_READY),  int'(sb.size() < 2));
      chk("flags",     int'(FLAGS),     int'(mdl_flags));
      chk("rd_a",      int'(RD_DATA_A), int'(mdl_regs[RD_ADDR_A]));
      chk("rd_b",      int'(RD_DATA_B), int'(mdl_regs[RD_ADDR_B]));
      if (!OUT_VALID) begin
        chk("empty_out", int'({OUT_DEST, OUT_DATA, OUT_FLAGS}), 0);
      end else if (sb.size() == 0) begin
        chk("unexpected_head", int'(OUT_VALID), 0);
      end else begin
        head_t = sb[0];
        chk("out_dest",  int'(OUT_DEST),  int'(head_t.dest));
        chk("out_data",  int'(OUT_DATA),  int'(head_t.data));
        chk("out_flags", int'(OUT_FLAGS), int'(head_t.fl));
        if (OUT_READY) begin
          void'(sb.pop_front());
          model_retire(head_t);
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rd_rand) begin
      RD_ADDR_A = 3'($urandom);
      RD_ADDR_B = 3'($urandom);
    end
  end

  task automatic send(input logic [4:0] op, input logic [2:0] dest, input logic we,
                      input logic [2:0] data, input logic [3:0] fl);
    int n = 0;
    bit done = 0;
    IN_VALID = 1'b1;
    IN_OP = op; IN_DEST = dest; IN_WE = we; RESU = data; {O, C, S, Z} = fl;
    while (!done) begin
      @(negedge CLK);
      #1;
      if (IN_READY) begin
        sb.push_back('{op: op, dest: dest, we: we, data: data, fl: fl});
        done = 1;
      end else if (++n > 60) begin
        chk("push_timeout", int'(IN_READY), 1);
        done = 1;
      end
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_OP = 5'($urandom); IN_DEST = 3'($urandom); IN_WE = 1'($urandom);
    RESU = 3'($urandom); {O, C, S, Z} = 4'($urandom);
  endtask

  task automatic wait_empty();
    int n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (sb.size() != 0 && n < 60);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_OP = '0; IN_DEST = '0; IN_WE = 1'b0; RESU = '0; {O, C, S, Z} = 4'd0;
    RD_ADDR_A = '0; RD_ADDR_B = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_in_ready",  int'(IN_READY),  1);
    chk("rst_flags",     int'(FLAGS),     0);

    // Arithmetic retire updates all four flags and writes the bank.
    OUT_READY = 1'b1;
    send(5'b00001, 3'd3, 1'b1, 3'b101, 4'b1010);
    wait_empty();
    rd_rand = 1'b0; RD_ADDR_A = 3'd3; #1;
    chk("s1_reg3",  int'(RD_DATA_A), 5);
    chk("s1_flags", int'(FLAGS), 4'b1010);

    // Logic retire keeps O,C.
    send(5'b01000, 3'd2, 1'b1, 3'b000, 4'b0101);
    wait_empty();
    RD_ADDR_A = 3'd2; #1;
    chk("s2_reg2",  int'(RD_DATA_A), 0);
    chk("s2_flags", int'(FLAGS), 4'b1001);
    rd_rand = 1'b1;

    // Stalled consumer: two entries fill the FIFO, third waits for space.
    OUT_READY = 1'b0;
    send(5'b00010, 3'd1, 1'b1, 3'd3, 4'b0011);
    send(5'b01001, 3'd5, 1'b1, 3'd6, 4'b1100);
    chk("s3_full", int'(IN_READY), 0);
    fork
      send(5'b00011, 3'd6, 1'b1, 3'd1, 4'b0111);
      begin
        repeat (3) @(posedge CLK);
        #1;
        chk("s3_hold_dest", int'(OUT_DEST), 1);
        chk("s3_hold_data", int'(OUT_DATA), 3);
        chk("s4_full_before_pop", int'(IN_READY), 0);
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("s4_ready_after_pop", int'(IN_READY), 1);
      end
    join
    wait_empty();

    // NOP with WE set leaves bank and flags untouched.
    send(5'b11111, 3'd4, 1'b1, 3'd7, 4'b1111);
    wait_empty();
    rd_rand = 1'b0; RD_ADDR_A = 3'd4; RD_ADDR_B = 3'd6; #1;
    chk("s5_reg4",  int'(RD_DATA_A), 0);
    chk("s5_reg6",  int'(RD_DATA_B), 1);
    chk("s5_flags", int'(FLAGS), 4'b0111);
    rd_rand = 1'b1;

    // Reset with two buffered entries drops them without effects.
    OUT_READY = 1'b0;
    send(5'b00000, 3'd0, 1'b1, 3'd7, 4'b1111);
    send(5'b10000, 3'd7, 1'b1, 3'd6, 4'b0011);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; OUT_READY = 1'b1;
    chk("s6_out_valid", int'(OUT_VALID), 0);
    chk("s6_busy",      int'(BUSY), 0);
    chk("s6_in_ready",  int'(IN_READY), 1);
    chk("s6_flags",     int'(FLAGS), 0);
    rd_rand = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RD_ADDR_A = 3'(i); RD_ADDR_B = 3'(7 - i); #1;
      chk("s6_reg_a", int'(RD_DATA_A), 0);
      chk("s6_reg_b", int'(RD_DATA_B), 0);
    end
    repeat (2) @(posedge CLK);
    #1;
    chk("s6_flags_later", int'(FLAGS), 0);
    rd_rand = 1'b1;

    // Randomized traffic with random consumer backpressure.
    stim_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          int gap;
          logic [4:0] op;
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge CLK); #1;
          end
          op = ($urandom_range(0, 7) == 0) ? 5'h1f : 5'($urandom);
          send(op, 3'($urandom), 1'($urandom), 3'($urandom), 4'($urandom));
        end
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge CLK); #1;
          OUT_READY = ($urandom_range(0, 3) != 0);
        end
      end
    join
    OUT_READY = 1'b1;
    wait_empty();
    repeat (2) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_wb.md
Name: ula_wb

Overview:
Writeback/retire stage directly downstream of the ULA. It captures RESU and the O/C/S/Z flags together with the destination tag, buffers them in a 2-entry FIFO with a valid/ready handshake, and retires them in order. On retire it writes the register bank, updates the architectural flag register per operation class, and presents a commit record to the monitor/trace port. Two asynchronous read ports on the register bank feed operand fetch, which is upstream of the ULA.

Parameters:
DATA_W, 3, width of RESU and of register-bank entries.
OP_W, 5, width of the operation code.
NREGS, 8, number of register-bank entries; the address width is clog2(NREGS).
DEPTH, 2, FIFO entries. Only the value 2 is supported.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RST  in  1  synchronous, active-high reset.
IN_VALID  in  1  ULA result valid this cycle.
IN_READY  out  1  stage can accept an entry.
IN_OP  in  OP_W  operation that produced the result.
IN_DEST  in  3  destination register index.
IN_WE  in  1  write RESU into the register bank on retire.
RESU  in  DATA_W  ULA result.
O, C, S, Z  in  1 each  ULA flags.
OUT_VALID  out  1  head entry is presented for commit.
OUT_READY  in  1  commit consumer accepts the head entry.
OUT_DEST  out  3  head destination.
OUT_DATA  out  DATA_W  head result.
OUT_FLAGS  out  4  head flags, ordered {O,C,S,Z}.
FLAGS  out  4  architectural flag register, ordered {O,C,S,Z}.
RD_ADDR_A, RD_ADDR_B  in  3  read addresses.
RD_DATA_A, RD_DATA_B  out  DATA_W  register-bank contents (combinational read).
BUSY  out  1  FIFO not empty, used by upstream for hazard stalls.

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - FIFO count=0, head/tail pointers=0.
  - All register-bank entries=0; FLAGS=4'b0000.
  - OUT_VALID=0, BUSY=0, IN_READY=1 from the next cycle.
  - OUT_DEST, OUT_DATA and OUT_FLAGS read 0 while empty.
  - Reset mid-operation discards every buffered entry. No write and no flag update is performed for those entries.
- Push: IN_VALID && IN_READY at an edge. The entry {OP, DEST, WE, RESU, O, C, S, Z} is stored at the tail.
- Pop: OUT_VALID && OUT_READY at an edge. The head entry retires.
- Push and pop in the same cycle: both occur and the count is unchanged.
- IN_READY = (count < DEPTH), from registered state only.
  - No combinational path from OUT_READY to IN_READY.
  - When full, a same-cycle pop does not enable a push.
- OUT_VALID = (count != 0). OUT_* come from the head entry.
- OUT_* and OUT_VALID stay stable while OUT_VALID && !OUT_READY.
- Latency: an entry pushed at edge N is visible on OUT_* after edge N (one cycle).
- Minimum residency is one cycle. There is no bypass from input to output.
- Pointers wrap modulo DEPTH.
- Op class is decoded from the head OP:
  - ARITH when OP[4:3]==2'b00.
  - NOP when OP==5'b11111.
  - LOGIC otherwise.
- Retire effects at the pop edge:
  - Register write: if WE && class!=NOP, reg[DEST] <= RESU.
  - Flag update:
    - ARITH: FLAGS <= {O,C,S,Z}.
    - LOGIC: FLAGS[1:0] <= {S,Z}; FLAGS[3:2] (O,C) are retained.
    - NOP: no write and FLAGS unchanged, even if WE=1.
- Read ports:
  - Pure combinational read of the bank; no forwarding from the FIFO.
  - A write at edge N is visible on RD_DATA after edge N.
  - Upstream uses BUSY to avoid RAW hazards.
- Both read ports may use the same address. A read may target the register being written; it returns the old value until the edge.
- IN_DEST and RD_ADDR are full-range for NREGS=8; there is no out-of-range case.
- X on inputs while IN_VALID=0 must not propagate into state.

Decomposition:
- Package ula_pkg holds:
  - Constants DATA_W, OP_W, OP_NOP=5'b11111.
  - typedef op_class_e {CLS_ARITH, CLS_LOGIC, CLS_NOP} and function op_class(op).
  - typedef struct wb_entry_t {op, dest, we, data, flags[3:0]}.
- One sub-module, ula_wb_fifo: a 2-entry synchronous FIFO of wb_entry_t with count/pointers and the valid/ready logic. It is parameterized on the entry type width.
- The register bank and flag register stay in ula_wb.

Test Plan:
1. Reset, then push ARITH OP=5'b00001, DEST=3, WE=1, RESU=3'b101, {O,C,S,Z}=1010, with OUT_READY=1 -> OUT_VALID one cycle after the push; after retire reg[3]=5 on RD_DATA_A(addr 3), FLAGS=4'b1010.
2. After scenario 1, retire LOGIC OP=5'b01000, DEST=2, RESU=3'b000, flags=0101 -> reg[2]=0; FLAGS=4'b1001 (O,C retained; S=0, Z=1).
3. OUT_READY=0 and push 3 consecutive entries -> IN_READY drops after 2 pushes; the third is held by upstream. OUT_* stays on entry 1. Raise OUT_READY -> retire order is 1, 2, 3.
4. Full FIFO, OUT_READY=1 and IN_VALID=1 in the same cycle -> pop only, count 2->1; IN_READY=1 the next cycle.
5. NOP entry with WE=1, DEST=4, RESU=7 -> reg[4] and FLAGS unchanged; commit record still presented.
6. Two entries buffered, RST pulsed -> count=0, OUT_VALID=0, BUSY=0, all regs=0, FLAGS=0; no retire effects from the dropped entries.
